// File: rtl/writeback_queue_pkg.sv
// Shared constants for the write-back queue: datapath width, register file size, default depth.
package writeback_queue_pkg;
   localparam int WORD_SIZE = 16;
   localparam int REG_SIZE  = 4;
   localparam int WBQ_DEPTH = 4;
   localparam int REG_IDX_W = $clog2(REG_SIZE);

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/writeback_queue_if.sv
// Producer, register-file write port and forwarding-query bundle of the write-back queue.
interface writeback_queue_if #(
   parameter int WORD_SIZE = writeback_queue_pkg::WORD_SIZE,
   parameter int DEPTH     = writeback_queue_pkg::WBQ_DEPTH
);
   import writeback_queue_pkg::*;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                 enqValid;
   reg_idx_t             enqReg;
   logic [WORD_SIZE-1:0] enqData;
   logic                 enqReady;
   logic                 drainEn;
   logic                 RegWrite;
   reg_idx_t             writeReg;
   logic [WORD_SIZE-1:0] writeData;
   reg_idx_t             lookupReg1;
   reg_idx_t             lookupReg2;
   logic                 fwdHit1;
   logic                 fwdHit2;
   logic [WORD_SIZE-1:0] fwdData1;
   logic [WORD_SIZE-1:0] fwdData2;
   logic [CNT_W-1:0]     count;

   modport master (
      output enqValid, enqReg, enqData, drainEn, lookupReg1, lookupReg2,
      input  enqReady, RegWrite, writeReg, writeData,
      input  fwdHit1, fwdHit2, fwdData1, fwdData2, count
   );

   modport slave (
      input  enqValid, enqReg, enqData, drainEn, lookupReg1, lookupReg2,
      output enqReady, RegWrite, writeReg, writeData,
      output fwdHit1, fwdHit2, fwdData1, fwdData2, count
   );
endinterface

// File: rtl/wbq_fwd_lookup.sv
// Youngest-match search over the occupied queue entries; purely combinational, no backpressure.
module wbq_fwd_lookup #(
   parameter int WORD_SIZE = writeback_queue_pkg::WORD_SIZE,
   parameter int DEPTH     = writeback_queue_pkg::WBQ_DEPTH,
   parameter int PTR_W     = $clog2(DEPTH)
) (
   input  writeback_queue_pkg::reg_idx_t query,
   input  writeback_queue_pkg::reg_idx_t ent_reg [DEPTH],
   input  logic [WORD_SIZE-1:0]          ent_dat [DEPTH],
   input  logic [DEPTH-1:0]              ent_vld,
   input  logic [PTR_W-1:0]              head,
   output logic                          hit,
   output logic [WORD_SIZE-1:0]          data
);
   logic [PTR_W-1:0] idx;

   // Walk from oldest to youngest so the last match written wins.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if (ent_vld[idx] && (ent_reg[idx] == query)) begin
            hit  = 1'b1;
            data = ent_dat[idx];
         end
      end
   end
endmodule

// File: rtl/writeback_queue.sv
// In-order queue of pending register writes with youngest-match forwarding; retire latency >= 1 cycle.
// enqReady drops when all DEPTH entries are occupied; drainEn throttles retirement to the register file.
module writeback_queue #(
   parameter int WORD_SIZE = writeback_queue_pkg::WORD_SIZE,
   parameter int DEPTH     = writeback_queue_pkg::WBQ_DEPTH
) (
   input logic              clk,
   input logic              reset,
   writeback_queue_if.slave bus
);
   import writeback_queue_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]     head;
   logic [PTR_W-1:0]     tail;
   logic [CNT_W-1:0]     cnt;
   reg_idx_t             ent_reg [DEPTH];
   logic [WORD_SIZE-1:0] ent_dat [DEPTH];
   logic [DEPTH-1:0]     ent_vld;
   logic [PTR_W-1:0]     age;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;

   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);
   assign push  = bus.enqValid && !full;
   assign pop   = bus.drainEn && !empty;

   assign bus.enqReady  = !full;
   assign bus.RegWrite  = pop;
   assign bus.writeReg  = empty ? '0 : ent_reg[head];
   assign bus.writeData = empty ? '0 : ent_dat[head];
   assign bus.count     = cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_reg[i] <= '0;
            ent_dat[i] <= '0;
         end
      end else begin
         if (push) begin
            ent_reg[tail] <= bus.enqReg;
            ent_dat[tail] <= bus.enqData;
            tail          <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // An entry is occupied when its distance from head is below the occupancy count.
   always_comb begin
      ent_vld = '0;
      age     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age        = PTR_W'(i) - head;
         ent_vld[i] = ({1'b0, age} < cnt);
      end
   end

   wbq_fwd_lookup #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) u_lookup1 (
      .query   (bus.lookupReg1),
      .ent_reg (ent_reg),
      .ent_dat (ent_dat),
      .ent_vld (ent_vld),
      .head    (head),
      .hit     (bus.fwdHit1),
      .data    (bus.fwdData1)
   );

   wbq_fwd_lookup #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) u_lookup2 (
      .query   (bus.lookupReg2),
      .ent_reg (ent_reg),
      .ent_dat (ent_dat),
      .ent_vld (ent_vld),
      .head    (head),
      .hit     (bus.fwdHit2),
      .data    (bus.fwdData2)
   );
endmodule

// File: tb/tb_writeback_queue.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_writeback_queue;
   import writeback_queue_pkg::*;

   localparam int W = 16;
   localparam int D = 4;

   typedef struct packed {
      logic [1:0]  r;
      logic [15:0] d;
   } ent_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   writeback_queue_if #(.WORD_SIZE(W), .DEPTH(D)) bus ();

   writeback_queue #(.WORD_SIZE(W), .DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Inputs change at the falling edge; outputs are then sampled 1 ns later.
   task automatic drive(input logic v, input logic [1:0] r, input logic [15:0] d,
                        input logic dr, input logic [1:0] l1, input logic [1:0] l2);
      @(negedge clk);
      bus.enqValid   = v;
      bus.enqReg     = r;
      bus.enqData    = d;
      bus.drainEn    = dr;
      bus.lookupReg1 = l1;
      bus.lookupReg2 = l2;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.enqValid = 1'b0;
      bus.drainEn  = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.enqValid = 1'b1; bus.enqReg = 2'd1; bus.enqData = 16'h5555;
      bus.drainEn  = 1'b1; bus.lookupReg1 = 2'd1; bus.lookupReg2 = 2'd0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.count); end
      tests++; if (bus.enqReady !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.enqReady); end
      tests++; if (bus.RegWrite !== 1'b0) begin fails++; $display("FAIL reset_regwrite got %b want 0", bus.RegWrite); end
      tests++; if (bus.writeReg !== 2'd0 || bus.writeData !== 16'h0) begin fails++; $display("FAIL reset_wport got %0d/%h want 0/0000", bus.writeReg, bus.writeData); end
      tests++; if (bus.fwdHit1 !== 1'b0 || bus.fwdData1 !== 16'h0) begin fails++; $display("FAIL reset_fwd got %b/%h want 0/0000", bus.fwdHit1, bus.fwdData1); end
      do_reset();
   endtask

   task automatic test_basic();
      drive(1, 2'd2, 16'h1234, 0, 2'd0, 2'd0);
      drive(0, 2'd0, 16'h0, 0, 2'd2, 2'd3);
      tests++; if (bus.count !== 3'd1) begin fails++; $display("FAIL basic_count got %0d want 1", bus.count); end
      tests++; if (bus.fwdHit1 !== 1'b1 || bus.fwdData1 !== 16'h1234) begin fails++; $display("FAIL basic_fwd got %b/%h want 1/1234", bus.fwdHit1, bus.fwdData1); end
      tests++; if (bus.fwdHit2 !== 1'b0) begin fails++; $display("FAIL basic_miss got %b want 0", bus.fwdHit2); end
      drive(0, 2'd0, 16'h0, 1, 2'd2, 2'd3);
      tests++; if (bus.RegWrite !== 1'b1 || bus.writeReg !== 2'd2 || bus.writeData !== 16'h1234) begin
         fails++; $display("FAIL basic_retire got %b/%0d/%h want 1/2/1234", bus.RegWrite, bus.writeReg, bus.writeData); end
      tests++; if (bus.fwdHit1 !== 1'b1) begin fails++; $display("FAIL basic_retiring_fwd got %b want 1", bus.fwdHit1); end
      drive(0, 2'd0, 16'h0, 0, 2'd2, 2'd3);
      tests++; if (bus.count !== 3'd0 || bus.RegWrite !== 1'b0) begin fails++; $display("FAIL basic_empty got %0d/%b want 0/0", bus.count, bus.RegWrite); end
   endtask

   task automatic test_same_reg();
      drive(1, 2'd1, 16'h0001, 0, 2'd1, 2'd1);
      drive(1, 2'd1, 16'h0002, 0, 2'd1, 2'd1);
      drive(0, 2'd0, 16'h0, 0, 2'd1, 2'd1);
      tests++; if (bus.fwdData1 !== 16'h0002 || bus.fwdHit1 !== 1'b1) begin fails++; $display("FAIL same_reg_fwd got %b/%h want 1/0002", bus.fwdHit1, bus.fwdData1); end
      drive(0, 2'd0, 16'h0, 1, 2'd1, 2'd1);
      tests++; if (bus.writeData !== 16'h0001) begin fails++; $display("FAIL same_reg_first got %h want 0001", bus.writeData); end
      drive(0, 2'd0, 16'h0, 1, 2'd1, 2'd1);
      tests++; if (bus.writeData !== 16'h0002 || bus.RegWrite !== 1'b1) begin fails++; $display("FAIL same_reg_second got %b/%h want 1/0002", bus.RegWrite, bus.writeData); end
      drive(0, 2'd0, 16'h0, 0, 2'd1, 2'd1);
      tests++; if (bus.count !== 3'd0 || bus.fwdHit1 !== 1'b0) begin fails++; $display("FAIL same_reg_empty got %0d/%b want 0/0", bus.count, bus.fwdHit1); end
   endtask

   task automatic test_full();
      drive(1, 2'd0, 16'hA000, 0, 2'd0, 2'd0);
      drive(1, 2'd1, 16'hA001, 0, 2'd0, 2'd0);
      drive(1, 2'd2, 16'hA002, 0, 2'd0, 2'd0);
      drive(1, 2'd0, 16'hA003, 0, 2'd0, 2'd0);
      drive(1, 2'd3, 16'hDEAD, 0, 2'd3, 2'd0);
      tests++; if (bus.count !== 3'd4 || bus.enqReady !== 1'b0) begin fails++; $display("FAIL full_ready got %0d/%b want 4/0", bus.count, bus.enqReady); end
      tests++; if (bus.fwdData2 !== 16'hA003) begin fails++; $display("FAIL full_youngest got %h want a003", bus.fwdData2); end
      drive(0, 2'd0, 16'h0, 0, 2'd3, 2'd0);
      tests++; if (bus.count !== 3'd4 || bus.fwdHit1 !== 1'b0) begin fails++; $display("FAIL full_ignored got %0d/%b want 4/0", bus.count, bus.fwdHit1); end
      drive(0, 2'd0, 16'h0, 1, 2'd3, 2'd0);
      tests++; if (bus.writeData !== 16'hA000) begin fails++; $display("FAIL full_head got %h want a000", bus.writeData); end
      drive(0, 2'd0, 16'h0, 0, 2'd3, 2'd0);
      tests++; if (bus.enqReady !== 1'b1 || bus.count !== 3'd3) begin fails++; $display("FAIL full_release got %b/%0d want 1/3", bus.enqReady, bus.count); end
      repeat (3) drive(0, 2'd0, 16'h0, 1, 2'd0, 2'd0);
      drive(0, 2'd0, 16'h0, 0, 2'd0, 2'd0);
      tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL full_flush got %0d want 0", bus.count); end
   endtask

   task automatic test_back_to_back();
      ent_t mq[$];
      drive(1, 2'd0, 16'hB000, 0, 2'd0, 2'd0);
      mq.push_back('{r: 2'd0, d: 16'hB000});
      drive(1, 2'd1, 16'hB001, 0, 2'd0, 2'd0);
      mq.push_back('{r: 2'd1, d: 16'hB001});
      for (int i = 0; i < 10; i++) begin
         drive(1, 2'(i), 16'hC000 + 16'(i), 1, 2'd0, 2'd0);
         tests++; if (bus.count !== 3'd2) begin fails++; $display("FAIL b2b_count[%0d] got %0d want 2", i, bus.count); end
         tests++; if (bus.RegWrite !== 1'b1 || bus.writeData !== mq[0].d || bus.writeReg !== mq[0].r) begin
            fails++; $display("FAIL b2b_head[%0d] got %b/%0d/%h want 1/%0d/%h", i, bus.RegWrite, bus.writeReg, bus.writeData, mq[0].r, mq[0].d); end
         void'(mq.pop_front());
         mq.push_back('{r: 2'(i), d: 16'hC000 + 16'(i)});
      end
      repeat (2) drive(0, 2'd0, 16'h0, 1, 2'd0, 2'd0);
      drive(0, 2'd0, 16'h0, 0, 2'd0, 2'd0);
      tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL b2b_drained got %0d want 0", bus.count); end
   endtask

   task automatic test_reset_mid();
      drive(1, 2'd1, 16'hE001, 0, 2'd1, 2'd0);
      drive(1, 2'd2, 16'hE002, 0, 2'd1, 2'd0);
      drive(1, 2'd3, 16'hE003, 0, 2'd1, 2'd0);
      drive(0, 2'd0, 16'h0, 0, 2'd1, 2'd0);
      tests++; if (bus.count !== 3'd3) begin fails++; $display("FAIL rmid_pre got %0d want 3", bus.count); end
      bus.drainEn = 1'b1;
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      tests++; if (bus.count !== 3'd0 || bus.enqReady !== 1'b1) begin fails++; $display("FAIL rmid_clear got %0d/%b want 0/1", bus.count, bus.enqReady); end
      tests++; if (bus.RegWrite !== 1'b0 || bus.writeData !== 16'h0 || bus.fwdHit1 !== 1'b0) begin
         fails++; $display("FAIL rmid_outs got %b/%h/%b want 0/0000/0", bus.RegWrite, bus.writeData, bus.fwdHit1); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests++; if (bus.RegWrite !== 1'b0) begin fails++; $display("FAIL rmid_release got %b want 0", bus.RegWrite); end
      drive(0, 2'd0, 16'h0, 1, 2'd1, 2'd0);
      tests++; if (bus.RegWrite !== 1'b0 || bus.count !== 3'd0) begin fails++; $display("FAIL rmid_after got %b/%0d want 0/0", bus.RegWrite, bus.count); end
   endtask

   task automatic test_enq_lookup();
      drive(1, 2'd3, 16'hBEEF, 1, 2'd3, 2'd3);
      tests++; if (bus.fwdHit1 !== 1'b0 || bus.RegWrite !== 1'b0) begin fails++; $display("FAIL nobypass got %b/%b want 0/0", bus.fwdHit1, bus.RegWrite); end
      drive(0, 2'd0, 16'h0, 1, 2'd3, 2'd0);
      tests++; if (bus.RegWrite !== 1'b1 || bus.writeReg !== 2'd3 || bus.writeData !== 16'hBEEF || bus.fwdHit1 !== 1'b1) begin
         fails++; $display("FAIL latency1 got %b/%0d/%h/%b want 1/3/beef/1", bus.RegWrite, bus.writeReg, bus.writeData, bus.fwdHit1); end
      drive(0, 2'd0, 16'h0, 0, 2'd3, 2'd0);
      tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL latency1_empty got %0d want 0", bus.count); end
   endtask

   task automatic test_random();
      ent_t        q[$];
      logic        v, dr, eh1, eh2;
      logic [1:0]  r, l1, l2;
      logic [15:0] d, ed1, ed2;
      int          sz;
      for (int c = 0; c < 400; c++) begin
         v  = ($urandom_range(0, 2) != 0);
         dr = ($urandom_range(0, 1) != 0);
         r  = 2'($urandom_range(0, 3));
         d  = 16'($urandom);
         l1 = 2'($urandom_range(0, 3));
         l2 = 2'($urandom_range(0, 3));
         drive(v, r, d, dr, l1, l2);
         sz = q.size();
         eh1 = 1'b0; ed1 = 16'h0; eh2 = 1'b0; ed2 = 16'h0;
         for (int k = 0; k < sz; k++) begin
            if (q[k].r == l1) begin eh1 = 1'b1; ed1 = q[k].d; end
            if (q[k].r == l2) begin eh2 = 1'b1; ed2 = q[k].d; end
         end
         tests++; if (bus.count !== 3'(sz)) begin fails++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, bus.count, sz); end
         tests++; if (bus.enqReady !== (sz < D)) begin fails++; $display("FAIL rnd_ready[%0d] got %b want %b", c, bus.enqReady, sz < D); end
         tests++; if (bus.RegWrite !== (dr && sz > 0)) begin fails++; $display("FAIL rnd_regwrite[%0d] got %b want %b", c, bus.RegWrite, dr && sz > 0); end
         tests++; if (bus.writeReg !== (sz > 0 ? q[0].r : 2'd0) || bus.writeData !== (sz > 0 ? q[0].d : 16'h0)) begin
            fails++; $display("FAIL rnd_wport[%0d] got %0d/%h", c, bus.writeReg, bus.writeData); end
         tests++; if (bus.fwdHit1 !== eh1 || bus.fwdData1 !== ed1) begin fails++; $display("FAIL rnd_fwd1[%0d] got %b/%h want %b/%h", c, bus.fwdHit1, bus.fwdData1, eh1, ed1); end
         tests++; if (bus.fwdHit2 !== eh2 || bus.fwdData2 !== ed2) begin fails++; $display("FAIL rnd_fwd2[%0d] got %b/%h want %b/%h", c, bus.fwdHit2, bus.fwdData2, eh2, ed2); end
         if (dr && sz > 0) void'(q.pop_front());
         if (v && sz < D) q.push_back('{r: r, d: d});
      end
   endtask

   initial begin
      bus.enqValid = 1'b0; bus.enqReg = 2'd0; bus.enqData = 16'h0;
      bus.drainEn  = 1'b0; bus.lookupReg1 = 2'd0; bus.lookupReg2 = 2'd0;
      test_reset();
      test_basic();
      test_same_reg();
      test_full();
      test_back_to_back();
      test_reset_mid();
      test_enq_lookup();
      do_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
